// File: rtl/div_unit_pkg.sv
// Shared decode constants and state type for the EX-stage divider.
package div_unit_pkg;

  // RV32M funct3 codes for the M extension. The divide group has funct3[2] set.
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
// It divides the operand magnitudes, producing one quotient bit per cycle.
// The signs are applied in a single FIX cycle at the end.
// Divide-by-zero and signed overflow complete in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] div_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  div_state_t state, nstate;

  logic             op_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [CNT_W-1:0] count_q;

  // Operand decode at acceptance time
  logic              in_signed, in_rem, a_neg, b_neg;
  logic              div_zero, sgn_ovf, special, accept;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;

  assign a_s       = rs1_value;
  assign b_s       = rs2_value;
  assign in_signed = (funct3 == F_DIV) || (funct3 == F_REM);
  assign in_rem    = (funct3 == F_REM) || (funct3 == F_REMU);
  assign a_neg     = in_signed && (a_s < 0);
  assign b_neg     = in_signed && (b_s < 0);
  assign a_mag     = a_neg ? twos_neg(rs1_value) : rs1_value;
  assign b_mag     = b_neg ? twos_neg(rs2_value) : rs2_value;
  assign div_zero  = (rs2_value == '0);
  assign sgn_ovf   = in_signed && (rs1_value == MIN_NEG) && (rs2_value == '1);
  assign special   = div_zero || sgn_ovf;
  assign accept    = start && !flush;

  // A zero divisor yields all-ones and the raw dividend.
  // Signed overflow yields the dividend and zero.
  assign special_res = div_zero ? (in_rem ? rs1_value : '1)
                                : (in_rem ? '0 : MIN_NEG);

  // One restoring step: shift the next dividend bit in, then subtract if it fits.
  // The extra remainder bit keeps the compare exact.
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            fits;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  assign rem_sh   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign fits     = (rem_sh >= {1'b0, divisor_q});
  assign rem_diff = rem_sh - {1'b0, divisor_q};
  assign quo_fix  = neg_quo_q ? twos_neg(quo_q) : quo_q;
  assign rem_fix  = neg_rem_q ? twos_neg(rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
  assign fix_res  = op_rem_q ? rem_fix : quo_fix;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic. A flush kills CALC/FIX and blocks a start in IDLE.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (accept) nstate = special ? DONE : CALC;
      CALC: if (flush) nstate = IDLE;
            else if (count_q == CNT_W'(XLEN - 1)) nstate = FIX;
      FIX:  nstate = flush ? IDLE : DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  // Datapath: operand capture, iteration, sign fix-up and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      count_q   <= '0;
      div_out   <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_rem_q  <= in_rem;
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          divisor_q <= b_mag;
          rem_q     <= '0;
          quo_q     <= a_mag;
          count_q   <= '0;
          if (special) div_out <= special_res;
        end
        CALC: if (!flush) begin
          rem_q   <= fits ? rem_diff : rem_sh;
          quo_q   <= {quo_q[XLEN-2:0], fits};
          count_q <= count_q + 1'b1;
        end
        FIX: if (!flush) div_out <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus flush/start/reset sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] div_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .busy(busy), .done(done), .div_out(div_out)
  );

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op and wait for done. Latency is counted in cycles from the start edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt);
    @(negedge clk);
    funct3 = f; rs1_value = a; rs2_value = b; start = 1'b1;
    lat = 0; bcnt = 0; res = 'x;
    while (lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (done) begin
        res = div_out;
        break;
      end
    end
    if (lat >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no done within %0d cycles", lat);
    end
  endtask

  initial begin
    logic [31:0] res, prior;
    int lat, bcnt, seen;

    vecs[0]  = '{"div_20_3",     F_DIV,  32'h00000014, 32'h00000003, 32'h00000006, 34};
    vecs[1]  = '{"rem_m7_2",     F_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
    vecs[2]  = '{"div_m7_2",     F_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
    vecs[3]  = '{"divu_max_2",   F_DIVU, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 34};
    vecs[4]  = '{"remu_max_2",   F_REMU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 34};
    vecs[5]  = '{"div_by0",      F_DIV,  32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[6]  = '{"rem_by0",      F_REM,  32'h12345678, 32'h00000000, 32'h12345678, 1};
    vecs[7]  = '{"divu_by0",     F_DIVU, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[8]  = '{"remu_by0",     F_REMU, 32'h87654321, 32'h00000000, 32'h87654321, 1};
    vecs[9]  = '{"div_ovf",      F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[10] = '{"rem_ovf",      F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[11] = '{"divu_no_ovf",  F_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[12] = '{"rem_7_m2",     F_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34};
    vecs[13] = '{"div_7_m2",     F_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[14] = '{"rem_m100_7",   F_REM,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 34};
    vecs[15] = '{"div_min_1",    F_DIV,  32'h80000000, 32'h00000001, 32'h80000000, 34};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = F_DIV; rs1_value = '0; rs2_value = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_div_out", div_out, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bcnt);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_busy_cycles"}, bcnt, (vecs[i].lat == 1) ? 0 : 33);
      check({vecs[i].name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({vecs[i].name, "_pulse_width"}, {31'd0, done}, 32'd0);
    end

    // A second start during CALC is ignored: the first op completes unchanged.
    @(negedge clk);
    funct3 = F_DIV; rs1_value = 32'd100; rs2_value = 32'd7; start = 1'b1;
    lat = 0; res = 'x;
    while (lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 5) begin
        funct3 = F_REMU; rs1_value = 32'd20; rs2_value = 32'd3; start = 1'b1;
      end
      if (done) begin res = div_out; break; end
    end
    check("ignored_start_res", res, 32'd14);
    check("ignored_start_lat", lat, 34);
    @(negedge clk);
    check("ignored_start_no_second_op", {31'd0, busy | done}, 32'd0);

    // A flush during CALC returns to IDLE with no done pulse and div_out held.
    prior = div_out;
    @(negedge clk);
    funct3 = F_DIV; rs1_value = 32'h00000014; rs2_value = 32'h00000003; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_drop", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("flush_no_done", seen, 0);
    check("flush_div_out_held", div_out, prior);

    // A new start after the flush completes normally.
    run_op(F_DIVU, 32'd100, 32'd7, res, lat, bcnt);
    check("post_flush_res", res, 32'd14);
    check("post_flush_lat", lat, 34);

    // A flush in IDLE blocks a simultaneous start.
    @(negedge clk);
    funct3 = F_DIV; rs1_value = 32'd9; rs2_value = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("idle_flush_blocks_start", seen, 0);
    check("idle_flush_div_out_held", div_out, 32'd14);

    // An asynchronous reset mid-operation clears everything without waiting for a clock edge.
    @(negedge clk);
    funct3 = F_DIV; rs1_value = 32'd1000; rs2_value = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_div_out", div_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(F_REMU, 32'd100, 32'd7, res, lat, bcnt);
    check("after_rst_res", res, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle RV32M divider for DIV/DIVU/REM/REMU. It sits in the EX stage beside the combinational multiplier and drives the same EX result mux. Decode raises start for a divide instruction, and the pipeline stalls on busy until done. The core is a restoring radix-2 shift-subtract engine that produces 1 quotient bit per cycle.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a divide; sampled only in IDLE
flush  input  1  kill the in-flight operation (branch mispredict/trap)
funct3  input  3  `F_DIV / `F_DIVU / `F_REM / `F_REMU
rs1_value  input  XLEN  dividend
rs2_value  input  XLEN  divisor
busy  output  1  operation in progress (CALC or FIX); pipeline stalls
done  output  1  single-cycle pulse; div_out is valid in the same cycle
div_out  output  XLEN  quotient or remainder, as selected by funct3

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_out=0; internal counters and registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start=1 at edge E0:
  - Latch funct3, sign flags, |dividend|, |divisor|, remainder=0, count=0.
  - Unsigned ops (DIVU, REMU) take magnitudes directly; no negation.
- Special cases are detected at E0 and go straight to DONE at E0:
  - Divisor==0: quotient = all-ones; remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000; remainder = 0.
  - done is high in the cycle after E0, giving latency 1.
- CALC, one iteration per edge:
  - {rem,quo} <<= 1; if rem >= divisor then rem -= divisor and quo[0] = 1; count++.
  - After XLEN iterations (edges E1..E32), go to FIX.
- FIX (edge E33):
  - Negate the quotient if signed op and the dividend sign != the divisor sign.
  - Negate the remainder if signed op and the dividend is negative.
  - Register the selected result into div_out; go to DONE.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge returns to IDLE unconditionally.
  - A normal operation asserts done 34 cycles after start is sampled.
- busy=1 in CALC and FIX; 0 in IDLE and DONE.
- start while not IDLE is ignored; there is no queueing.
- flush:
  - In CALC or FIX: next edge goes to IDLE, no done pulse, div_out unchanged.
  - In DONE: the pulse still occurs (the instruction has already completed).
  - In IDLE: overrides start in the same cycle, so the operation is not accepted.
- div_out holds the last result until the next done.
- Async reset mid-operation aborts immediately to the reset values.
- The remainder register is XLEN+1 bits so the compare/subtract cannot overflow.

Decomposition:
- Shared package / mydefine.sv:
  - `F_DIV=3'b100, `F_DIVU=3'b101, `F_REM=3'b110, `F_REMU=3'b111, alongside the existing MUL codes.
  - div_state_t enum {IDLE, CALC, FIX, DONE}.
- No sub-module; the iteration datapath and FSM stay in div_unit. The EX result mux, which selects between the multiplier and div_unit, lives in the EX stage, not here.

Test Plan:
- DIV 20/3 (rs1=0x14, rs2=0x3) -> done exactly 34 cycles after start, div_out=0x00000006; busy high for 33 cycles.
- REM -7/2 (0xFFFFFFF9, 0x2) -> div_out=0xFFFFFFFF. DIV of the same operands -> 0xFFFFFFFD.
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU 0xFFFFFFFF/2 -> 0x00000001.
- DIV x/0 (x=0x12345678):
  - DIV -> 0xFFFFFFFF with done 1 cycle after start.
  - REM -> 0x12345678 with done 1 cycle after start.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with 1-cycle latency. REM of the same operands -> 0x00000000.
- Start a DIV, pulse flush at cycle 10 -> IDLE next edge, no done, div_out keeps its prior value. A second start during CALC is ignored. A new start after flush completes normally.
